mem_stall_bridge: RTL and testbench

Sits between `mips_cpu_harvard` and memories whose reads and writes take one or more cycles, such as registered-read ROM and RAM models. It freezes the CPU by holding `clock_enable` low while it fetches the instruction word at `instr_address`. It then performs the data access the frozen instruction requests, if any, and releases the CPU for exactly one enabled cycle with both words held stable. It also flags memory timeouts and illegal bus requests, and counts stall cycles for performance reporting in the CPU testbench.

---
 rtl/mem_stall_bridge_if.sv | 52 +++++
 rtl/mem_stall_bridge.sv | 132 +++++++++++++
 tb/tb_mem_stall_bridge.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stall_bridge_if.sv
// Bus bundles around the stall bridge: the CPU-facing side and the memory-facing side.
// On each bundle the master drives requests and the slave answers them.

interface cpu_bus_if;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        clock_enable;

    // CPU side
    modport master (
        output instr_address, data_address, data_read, data_write, data_writedata,
        input  instr_readdata, data_readdata, clock_enable
    );

    // Bridge side
    modport slave (
        input  instr_address, data_address, data_read, data_write, data_writedata,
        output instr_readdata, data_readdata, clock_enable
    );
endinterface

interface mem_bus_if;
    logic        mem_instr_req;
    logic [31:0] mem_instr_addr;
    logic [31:0] mem_instr_rdata;
    logic        mem_instr_valid;
    logic        mem_data_req;
    logic        mem_data_we;
    logic [31:0] mem_data_addr;
    logic [31:0] mem_data_wdata;
    logic [31:0] mem_data_rdata;
    logic        mem_data_valid;

    // Bridge side
    modport master (
        output mem_instr_req, mem_instr_addr, mem_data_req, mem_data_we,
               mem_data_addr, mem_data_wdata,
        input  mem_instr_rdata, mem_instr_valid, mem_data_rdata, mem_data_valid
    );

    // Memory side
    modport slave (
        input  mem_instr_req, mem_instr_addr, mem_data_req, mem_data_we,
               mem_data_addr, mem_data_wdata,
        output mem_instr_rdata, mem_instr_valid, mem_data_rdata, mem_data_valid
    );
endinterface

// File: rtl/mem_stall_bridge.sv
// Freezes a single-cycle CPU while a multi-cycle instruction fetch and the
// optional data access complete, then lets it run for exactly one cycle.
// Also raises a sticky fault on memory timeouts or illegal bus requests and
// counts stalled cycles.

module mem_stall_bridge #(
    parameter int unsigned TIMEOUT = 64   // legal range 2..255
) (
    input  logic             clk,
    input  logic             reset,
    cpu_bus_if.slave         cpu,
    mem_bus_if.master        mem,
    output logic             bus_error,
    output logic [31:0]      stall_cycles
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] stall_q, stall_d;

    logic data_load, data_store, data_both, data_access;
    logic instr_req, data_req, instr_done, data_done, timed_out;

    // Decode the frozen instruction's bus request and the handshake events.
    assign data_load   = cpu.data_read  & ~cpu.data_write;
    assign data_store  = cpu.data_write & ~cpu.data_read;
    assign data_both   = cpu.data_read  &  cpu.data_write;
    assign data_access = data_load | data_store;

    // Requests are pure functions of state, so they drop the cycle after the
    // state moves on; a valid seen while the request is low is ignored.
    assign instr_req  = (state_q == ST_FETCH);
    assign data_req   = (state_q == ST_DATA) & data_access;
    assign instr_done = instr_req & mem.mem_instr_valid;
    assign data_done  = data_req  & mem.mem_data_valid;
    assign timed_out  = (wait_q == WAIT_LIMIT);

    // Next-state, wait counter, capture registers and stall counter.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        wait_d  = wait_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        stall_d = stall_q;

        case (state_q)
            ST_FETCH: begin
                if (instr_done) begin
                    instr_d = mem.mem_instr_rdata;
                    state_d = ST_DATA;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DATA: begin
                if (data_both) begin
                    state_d = ST_FAULT;
                end else if (!data_access) begin
                    state_d = ST_EXEC;
                end else if (data_done) begin
                    if (data_load) begin
                        rdata_d = mem.mem_data_rdata;
                    end
                    state_d = ST_EXEC;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_EXEC:  state_d = ST_FETCH;
            default:  state_d = ST_FAULT;   // FAULT is left only by reset
        endcase

        // A valid on the timeout cycle is handled above first, so it wins.
        if (state_d != state_q) begin
            wait_d = '0;
        end

        // Stall count saturates instead of wrapping.
        if (state_q != ST_EXEC && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
            instr_q <= '0;
            rdata_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            stall_q <= stall_d;
        end
    end

    // Enable stays high during reset so the CPU's own synchronous reset lands.
    assign cpu.clock_enable   = reset | (state_q == ST_EXEC);
    assign cpu.instr_readdata = instr_q;
    assign cpu.data_readdata  = rdata_q;

    // Address, data and we come straight from the frozen CPU, so they hold while req is high.
    assign mem.mem_instr_req  = instr_req;
    assign mem.mem_instr_addr = cpu.instr_address;
    assign mem.mem_data_req   = data_req;
    assign mem.mem_data_we    = data_req & cpu.data_write;
    assign mem.mem_data_addr  = cpu.data_address;
    assign mem.mem_data_wdata = cpu.data_writedata;

    assign bus_error    = (state_q == ST_FAULT);
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_stall_bridge.sv
// Directed bench for mem_stall_bridge: a per-cycle vector table for the NOP
// loop and a 3-wait-state load, then hand-written sequences for the store,
// reset during a read, illegal request, timeout and valid-at-timeout cases.

module tb_mem_stall_bridge;

    localparam logic [31:0] NOP   = 32'h0000_0020;
    localparam logic [31:0] LW    = 32'h8C02_1000;
    localparam logic [31:0] SW    = 32'hAC02_2004;
    localparam logic [31:0] BEEF  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_error;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    cpu_bus_if cpu ();
    mem_bus_if mem ();

    mem_stall_bridge #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu          (cpu),
        .mem          (mem),
        .bus_error    (bus_error),
        .stall_cycles (stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge, then let outputs settle.
    task automatic drive(input logic r, input logic iv, input logic dv);
        @(negedge clk);
        reset               = r;
        mem.mem_instr_valid = iv;
        mem.mem_data_valid  = dv;
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic        iv;
        logic        dv;
        logic [31:0] irdata;
        logic [31:0] drdata;
        logic        ce;
        logic        ireq;
        logic        dreq;
        logic [31:0] ird;
        logic [31:0] drd;
        logic [31:0] stall;
    } vec_t;

    function automatic vec_t v(input logic rst, rd, wr, iv, dv,
                               input logic [31:0] irdata, drdata,
                               input logic ce, ireq, dreq,
                               input logic [31:0] ird, drd, stall);
        vec_t t;
        t.rst = rst; t.rd = rd; t.wr = wr; t.iv = iv; t.dv = dv;
        t.irdata = irdata; t.drdata = drdata;
        t.ce = ce; t.ireq = ireq; t.dreq = dreq;
        t.ird = ird; t.drd = drd; t.stall = stall;
        return t;
    endfunction

    vec_t vecs [17];

    initial begin
        // One row per cycle: inputs, then the outputs expected in that cycle.
        //              rst rd wr iv dv irdata drdata  ce ireq dreq ird  drd   stall
        vecs[0]  = v(1, 0, 0, 0, 0, 0,   0,     1, 1, 0, 0,   0,    0);   // reset
        vecs[1]  = v(0, 0, 0, 0, 0, 0,   0,     0, 1, 0, 0,   0,    0);   // FETCH
        vecs[2]  = v(0, 0, 0, 1, 0, NOP, 0,     0, 1, 0, 0,   0,    1);   // FETCH valid
        vecs[3]  = v(0, 0, 0, 0, 0, NOP, 0,     0, 0, 0, NOP, 0,    2);   // DATA, no access
        vecs[4]  = v(0, 0, 0, 0, 0, NOP, 0,     1, 0, 0, NOP, 0,    3);   // EXEC
        vecs[5]  = v(0, 0, 0, 0, 0, NOP, 0,     0, 1, 0, NOP, 0,    3);
        vecs[6]  = v(0, 0, 0, 1, 0, NOP, 0,     0, 1, 0, NOP, 0,    4);
        vecs[7]  = v(0, 0, 0, 0, 0, NOP, 0,     0, 0, 0, NOP, 0,    5);
        vecs[8]  = v(0, 0, 0, 0, 0, NOP, 0,     1, 0, 0, NOP, 0,    6);   // 4-cycle period
        vecs[9]  = v(0, 0, 0, 0, 0, LW,  0,     0, 1, 0, NOP, 0,    6);   // lw fetch
        vecs[10] = v(0, 0, 0, 1, 0, LW,  0,     0, 1, 0, NOP, 0,    7);
        vecs[11] = v(0, 1, 0, 0, 0, LW,  BEEF,  0, 0, 1, LW,  0,    8);   // load req rises
        vecs[12] = v(0, 1, 0, 0, 0, LW,  BEEF,  0, 0, 1, LW,  0,    9);
        vecs[13] = v(0, 1, 0, 0, 0, LW,  BEEF,  0, 0, 1, LW,  0,    10);
        vecs[14] = v(0, 1, 0, 0, 0, LW,  BEEF,  0, 0, 1, LW,  0,    11);
        vecs[15] = v(0, 1, 0, 0, 1, LW,  BEEF,  0, 0, 1, LW,  0,    12);  // valid
        vecs[16] = v(0, 1, 0, 0, 0, LW,  BEEF,  1, 0, 0, LW,  BEEF, 13);  // EXEC, 8-cycle period

        reset               = 1'b1;
        cpu.instr_address   = 32'h0040_0000;
        cpu.data_address    = 32'h0000_1000;
        cpu.data_writedata  = 32'h0;
        cpu.data_read       = 1'b0;
        cpu.data_write      = 1'b0;
        mem.mem_instr_rdata = 32'h0;
        mem.mem_instr_valid = 1'b0;
        mem.mem_data_rdata  = 32'h0;
        mem.mem_data_valid  = 1'b0;
        repeat (2) @(posedge clk);

        // ---------------- table: NOP loop and 3-wait-state load ----------------
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            reset               = vecs[i].rst;
            cpu.data_read       = vecs[i].rd;
            cpu.data_write      = vecs[i].wr;
            mem.mem_instr_valid = vecs[i].iv;
            mem.mem_data_valid  = vecs[i].dv;
            mem.mem_instr_rdata = vecs[i].irdata;
            mem.mem_data_rdata  = vecs[i].drdata;
            #1;
            check($sformatf("v%0d clock_enable", i),   cpu.clock_enable,   vecs[i].ce);
            check($sformatf("v%0d mem_instr_req", i),  mem.mem_instr_req,  vecs[i].ireq);
            check($sformatf("v%0d mem_data_req", i),   mem.mem_data_req,   vecs[i].dreq);
            check($sformatf("v%0d mem_data_we", i),    mem.mem_data_we,    1'b0);
            check($sformatf("v%0d bus_error", i),      bus_error,          1'b0);
            check($sformatf("v%0d instr_readdata", i), cpu.instr_readdata, vecs[i].ird);
            check($sformatf("v%0d data_readdata", i),  cpu.data_readdata,  vecs[i].drd);
            check($sformatf("v%0d stall_cycles", i),   stall_cycles,       vecs[i].stall);
            check($sformatf("v%0d mem_data_addr", i),  mem.mem_data_addr,  32'h0000_1000);
        end

        // ---------------- store with acknowledge two cycles after req ----------------
        cpu.data_read       = 1'b0;
        cpu.data_write      = 1'b0;
        cpu.data_address    = 32'h0000_2004;
        cpu.data_writedata  = 32'h1234_5678;
        mem.mem_instr_rdata = SW;
        drive(0, 0, 0);
        check("sw fetch addr", mem.mem_instr_addr, 32'h0040_0000);
        drive(0, 1, 0);
        cpu.data_write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, (i == 2));
            check($sformatf("sw%0d req", i),   mem.mem_data_req,   1'b1);
            check($sformatf("sw%0d we", i),    mem.mem_data_we,    1'b1);
            check($sformatf("sw%0d addr", i),  mem.mem_data_addr,  32'h0000_2004);
            check($sformatf("sw%0d wdata", i), mem.mem_data_wdata, 32'h1234_5678);
        end
        drive(0, 0, 0);
        check("sw exec ce",    cpu.clock_enable,   1'b1);
        check("sw exec req",   mem.mem_data_req,   1'b0);
        check("sw readdata",   cpu.data_readdata,  BEEF);
        check("sw instr",      cpu.instr_readdata, SW);
        check("sw stall",      stall_cycles,       32'd18);

        // ---------------- reset while a read is outstanding ----------------
        cpu.data_write      = 1'b0;
        cpu.data_address    = 32'h0000_1000;
        mem.mem_instr_rdata = LW;
        mem.mem_data_rdata  = 32'hCAFE_F00D;
        drive(0, 0, 0);
        drive(0, 1, 0);
        cpu.data_read = 1'b1;
        drive(0, 0, 0);
        check("rst pre req",   mem.mem_data_req,   1'b1);
        drive(1, 0, 0);
        check("rst ce",        cpu.clock_enable,   1'b1);
        drive(0, 0, 0);
        check("rst data_req",  mem.mem_data_req,   1'b0);
        check("rst instr_req", mem.mem_instr_req,  1'b1);
        check("rst readdata",  cpu.data_readdata,  32'h0);
        check("rst instr",     cpu.instr_readdata, 32'h0);
        check("rst stall",     stall_cycles,       32'h0);
        drive(0, 0, 1);                          // late data valid
        check("late req",      mem.mem_data_req,   1'b0);
        drive(0, 0, 0);
        check("late readdata", cpu.data_readdata,  32'h0);
        check("late fetch",    mem.mem_instr_req,  1'b1);
        check("late stall",    stall_cycles,       32'd2);

        // ---------------- read and write both asserted ----------------
        cpu.data_read = 1'b0;
        drive(0, 1, 0);
        cpu.data_read  = 1'b1;
        cpu.data_write = 1'b1;
        drive(0, 0, 0);
        check("both data req", mem.mem_data_req,   1'b0);
        check("both err pre",  bus_error,          1'b0);
        drive(0, 0, 0);
        check("both err",      bus_error,          1'b1);
        check("both data req2",mem.mem_data_req,   1'b0);
        check("both ireq",     mem.mem_instr_req,  1'b0);
        check("both ce",       cpu.clock_enable,   1'b0);
        check("both stall",    stall_cycles,       32'd5);
        drive(0, 1, 0);
        check("both sticky",   bus_error,          1'b1);
        check("both stall2",   stall_cycles,       32'd6);

        // ---------------- instruction memory never answers ----------------
        cpu.data_read  = 1'b0;
        cpu.data_write = 1'b0;
        drive(1, 0, 0);
        check("to reset ce",   cpu.clock_enable,   1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0);
            check($sformatf("to%0d ireq", i), mem.mem_instr_req, 1'b1);
            check($sformatf("to%0d err", i),  bus_error,         1'b0);
        end
        drive(0, 0, 0);
        check("to err",        bus_error,          1'b1);
        check("to ce",         cpu.clock_enable,   1'b0);
        check("to ireq",       mem.mem_instr_req,  1'b0);
        check("to stall",      stall_cycles,       32'd8);
        drive(0, 0, 0);
        check("to stall2",     stall_cycles,       32'd9);
        drive(1, 0, 0);
        check("to rst ce",     cpu.clock_enable,   1'b1);

        // ---------------- valid on the cycle the timeout would fire ----------------
        mem.mem_instr_rdata = NOP;
        drive(0, 0, 0);
        check("to clr err",    bus_error,          1'b0);
        check("to clr stall",  stall_cycles,       32'h0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0);
        end
        drive(0, 1, 0);
        check("race err",      bus_error,          1'b0);
        drive(0, 0, 0);
        check("race err2",     bus_error,          1'b0);
        check("race data st",  mem.mem_instr_req,  1'b0);
        check("race instr",    cpu.instr_readdata, NOP);
        check("race stall",    stall_cycles,       32'd8);
        drive(0, 0, 0);
        check("race exec",     cpu.clock_enable,   1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
